countdown_60x60: RTL

//  mm:ss countdown timer in packed BCD: decrements seconds 59..00 with borrow into minutes 59..00.

---
 rtl/countdown_60x60.sv | 130 +++++++++++++
 1 files changed

// File: rtl/countdown_60x60.sv
// mm:ss packed-BCD countdown timer with load/start/pause control and a timed DONE hold.
// Latency: every output is registered; it changes one CP cycle after the input that causes it.
// Backpressure: none. Pulse inputs are acted on in the cycle they are sampled. EN is a free-running strobe.
module countdown_60x60 #(
  parameter int DONE_TICKS = 5
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] Cnt_min,
  output logic [7:0] Cnt_sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [3:0] tick_q, tick_d;
  logic       err_q, err_d;

  // A packed BCD byte is valid when its tens digit is 0..5 and its ones digit is 0..9.
  function automatic logic bcd60_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // Decrement one packed BCD byte. The caller guarantees the byte is nonzero.
  // A zero ones digit borrows from the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else                return {v[7:4] - 4'd1, 4'd9};
  endfunction

  logic cnt_zero;
  assign cnt_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // Next-state logic. Per-cycle input priority is load > pause > start > EN.
  // A load cycle, valid or not, is not also used by the lower-priority inputs.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = tick_q;
    err_d   = 1'b0;
    if (load) begin
      if (bcd60_ok(set_min) && bcd60_ok(set_sec)) begin
        min_d   = set_min;
        sec_d   = set_sec;
        state_d = IDLE;
        tick_d  = 4'd0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cnt_zero) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (EN && !cnt_zero) begin
            if (sec_q != 8'h00) begin
              sec_d = bcd_dec(sec_q);
            end else begin
              sec_d = 8'h59;
              min_d = bcd_dec(min_q);
            end
            // Only the step from 00:01 can reach 00:00.
            if (min_q == 8'h00 && sec_q == 8'h01) begin
              state_d = DONE;
              tick_d  = 4'd0;
            end
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (EN) begin
            if (tick_q + 4'd1 >= 4'(DONE_TICKS)) begin
              state_d = IDLE;
              tick_d  = 4'd0;
            end else begin
              tick_d = tick_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and count registers, with synchronous reset.
  always_ff @(posedge CP) begin
    if (reset) begin
      state_q <= IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      tick_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign Cnt_min  = min_q;
  assign Cnt_sec  = sec_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign load_err = err_q;

endmodule
